demux1_2byte: RTL and testbench

- Buffered 1-to-2 byte demultiplexer: the write-side counterpart of the 2:1 byte mux.
- Steers each accepted input byte to one of two destination queues, chosen by `select`.
- Each queue drains independently through a valid/ready handshake.
- Sits between a single byte producer (ALU/bus driver) and two consumers, e.g. register-file write port and output latch.

---
 rtl/demux1_2byte_pkg.sv | 21 ++
 rtl/demux1_2byte_byte_fifo.sv | 78 +++++++
 rtl/demux1_2byte.sv | 93 +++++++++
 tb/tb_demux1_2byte.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux1_2byte_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux1_2byte_pkg
// Description : Shared byte width, default queue depth and destination
//               encoding for the buffered 1-to-2 byte demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux1_2byte_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 2;

    typedef logic [0:BYTE_W-1] byte_t;

    typedef enum logic {
        DEST_Q0 = 1'b0,
        DEST_Q1 = 1'b1
    } dest_e;

endpackage : demux1_2byte_pkg
`default_nettype wire

// File: rtl/demux1_2byte_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Byte queue with a registered head output; DEPTH entries,
//               power of two. Pushes when full and pops when empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import demux1_2byte_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  byte_t         wr_data,
    input  logic          rd_en,
    output byte_t         rd_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic          do_push;
    logic          do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign do_push    = wr_en && !full;
    assign do_pop     = rd_en && !empty;
    assign rd_ptr_nxt = rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end

            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Head register: the entry behind the head is only valid when
            // two or more bytes are queued; otherwise the incoming byte wins.
            // An emptying pop leaves the last head visible.
            if (do_push && empty) begin
                rd_data <= wr_data;
            end else if (do_pop && (count > CW'(1))) begin
                rd_data <= mem[rd_ptr_nxt];
            end else if (do_pop && do_push) begin
                rd_data <= wr_data;
            end
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/demux1_2byte.sv
`default_nettype none
// ============================================================================
// Module      : demux1_2byte
// Description : Buffered 1-to-2 byte demultiplexer steering each accepted
//               byte into one of two independently drained queues.
//               Optional DEMUX1_2BYTE_BROADCAST_EN adds a broadcast input that
//               writes a byte into both queues at once.
// Revision    : 1.0 - initial release
// ============================================================================
module demux1_2byte
    import demux1_2byte_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [0:7]    in,
    input  logic          in_valid,
    input  logic          select,
`ifdef DEMUX1_2BYTE_BROADCAST_EN
    input  logic          broadcast,
`endif
    output logic          in_ready,
    output logic [0:7]    out0,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [0:7]    out1,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [CW-1:0] count0,
    output logic [CW-1:0] count1
);

    dest_e dest;
    logic  full0;
    logic  full1;
    logic  empty0;
    logic  empty1;
    logic  sel_full;
    logic  to_q0;
    logic  to_q1;
    logic  accept;

    assign dest     = dest_e'(select);
    assign sel_full = (dest == DEST_Q1) ? full1 : full0;

    // Ready depends only on registered occupancy and the steering inputs,
    // never on the consumer handshakes.
`ifdef DEMUX1_2BYTE_BROADCAST_EN
    assign in_ready = !reset && (broadcast ? !(full0 || full1) : !sel_full);
    assign to_q0    = broadcast || (dest == DEST_Q0);
    assign to_q1    = broadcast || (dest == DEST_Q1);
`else
    assign in_ready = !reset && !sel_full;
    assign to_q0    = (dest == DEST_Q0);
    assign to_q1    = (dest == DEST_Q1);
`endif

    assign accept     = in_valid && in_ready;
    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_q0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept && to_q0),
        .wr_data (in),
        .rd_en   (out0_ready),
        .rd_data (out0),
        .empty   (empty0),
        .full    (full0),
        .count   (count0)
    );

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_q1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept && to_q1),
        .wr_data (in),
        .rd_en   (out1_ready),
        .rd_data (out1),
        .empty   (empty1),
        .full    (full1),
        .count   (count1)
    );

endmodule : demux1_2byte
`default_nettype wire

// File: tb/tb_demux1_2byte.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux1_2byte
// Description : Self-checking bench for demux1_2byte with a queue-based
//               reference model plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1_2byte;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [0:7]    din = 8'h00;
    logic          in_valid = 1'b0;
    logic          select = 1'b0;
    logic          in_ready;
    logic [0:7]    out0;
    logic          out0_valid;
    logic          out0_ready = 1'b0;
    logic [0:7]    out1;
    logic          out1_valid;
    logic          out1_ready = 1'b0;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;
`ifdef DEMUX1_2BYTE_BROADCAST_EN
    logic          broadcast = 1'b0;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pops0     = 0;
    bit mon_en    = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last0 = 8'h00;
    logic [7:0] last1 = 8'h00;

    always #5 clk = ~clk;

    demux1_2byte #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (din),
        .in_valid   (in_valid),
        .select     (select),
`ifdef DEMUX1_2BYTE_BROADCAST_EN
        .broadcast  (broadcast),
`endif
        .in_ready   (in_ready),
        .out0       (out0),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1       (out1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count0     (count0),
        .count1     (count1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: at each falling edge compare DUT state to the model, then
    // advance the model by what the next rising edge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            logic       bc;
            logic       exp_ready;
            logic       acc;
            logic [7:0] exp0;
            logic [7:0] exp1;
`ifdef DEMUX1_2BYTE_BROADCAST_EN
            bc = broadcast;
`else
            bc = 1'b0;
`endif
            if (reset)
                exp_ready = 1'b0;
            else if (bc)
                exp_ready = (q0.size() < DEPTH) && (q1.size() < DEPTH);
            else
                exp_ready = select ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
            exp0 = (q0.size() > 0) ? q0[0] : last0;
            exp1 = (q1.size() > 0) ? q1[0] : last1;

            total_cnt++;
            if (in_ready !== exp_ready) $display("FAIL sb_in_ready got %b exp %b @%0t", in_ready, exp_ready, $time);
            else pass_cnt++;
            total_cnt++;
            if (count0 !== CW'(q0.size())) $display("FAIL sb_count0 got %0d exp %0d @%0t", count0, q0.size(), $time);
            else pass_cnt++;
            total_cnt++;
            if (count1 !== CW'(q1.size())) $display("FAIL sb_count1 got %0d exp %0d @%0t", count1, q1.size(), $time);
            else pass_cnt++;
            total_cnt++;
            if (out0_valid !== (q0.size() > 0)) $display("FAIL sb_out0_valid got %b exp %b @%0t", out0_valid, (q0.size() > 0), $time);
            else pass_cnt++;
            total_cnt++;
            if (out1_valid !== (q1.size() > 0)) $display("FAIL sb_out1_valid got %b exp %b @%0t", out1_valid, (q1.size() > 0), $time);
            else pass_cnt++;
            total_cnt++;
            if (out0 !== exp0) $display("FAIL sb_out0 got %h exp %h @%0t", out0, exp0, $time);
            else pass_cnt++;
            total_cnt++;
            if (out1 !== exp1) $display("FAIL sb_out1 got %h exp %h @%0t", out1, exp1, $time);
            else pass_cnt++;

            if (reset) begin
                q0.delete();
                q1.delete();
                last0 = 8'h00;
                last1 = 8'h00;
            end else begin
                acc = in_valid && exp_ready;
                if (out0_ready && q0.size() > 0) begin
                    last0 = q0.pop_front();
                    pops0++;
                end
                if (out1_ready && q1.size() > 0) begin
                    last1 = q1.pop_front();
                end
                if (acc && (bc || !select)) q0.push_back(din);
                if (acc && (bc || select))  q1.push_back(din);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        select = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready_sel0 got %b exp 0", in_ready); else pass_cnt++;
        select = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL rst_in_ready_sel1 got %b exp 0", in_ready); else pass_cnt++;
        total_cnt++;
        if ({count0, count1} !== '0) $display("FAIL rst_counts got %0d/%0d exp 0/0", count0, count1); else pass_cnt++;
        total_cnt++;
        if ({out0_valid, out1_valid} !== 2'b00) $display("FAIL rst_valids got %b%b exp 00", out0_valid, out1_valid); else pass_cnt++;
        total_cnt++;
        if ({out0, out1} !== 16'h0000) $display("FAIL rst_outs got %h/%h exp 00/00", out0, out1); else pass_cnt++;
        tick();
        reset = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL idle_in_ready_sel1 got %b exp 1", in_ready); else pass_cnt++;
        select = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL idle_in_ready_sel0 got %b exp 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_steering();
        in_valid = 1'b1;
        din = 8'hA5; select = 1'b0; tick();
        din = 8'h3C; select = 1'b1; tick();
        din = 8'h0F; select = 1'b0; tick();
        in_valid = 1'b0;
        total_cnt++;
        if (count0 !== 2 || count1 !== 1) $display("FAIL steer_counts got %0d/%0d exp 2/1", count0, count1); else pass_cnt++;
        total_cnt++;
        if (out0 !== 8'hA5 || out1 !== 8'h3C) $display("FAIL steer_heads got %h/%h exp a5/3c", out0, out1); else pass_cnt++;
        out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
        total_cnt++;
        if (out0 !== 8'h0F || count0 !== 1) $display("FAIL steer_pop0 got %h cnt %0d exp 0f cnt 1", out0, count0); else pass_cnt++;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        tick();
        out0_ready = 1'b0; out1_ready = 1'b0;
        total_cnt++;
        if (out0_valid !== 1'b0 || out0 !== 8'h0F || out1 !== 8'h3C)
            $display("FAIL steer_hold got v%b %h/%h exp v0 0f/3c", out0_valid, out0, out1);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        in_valid = 1'b1; select = 1'b0;
        din = 8'h11; tick();
        din = 8'h22; tick();
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL fill_ready_sel0 got %b exp 0", in_ready); else pass_cnt++;
        select = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL fill_ready_sel1 got %b exp 1", in_ready); else pass_cnt++;
        in_valid = 1'b1; din = 8'h33;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (count1 !== 1 || out1 !== 8'h33 || count0 !== 2 || out0 !== 8'h11)
            $display("FAIL fill_other_q got c1=%0d %h c0=%0d %h exp 1 33 2 11", count1, out1, count0, out0);
        else pass_cnt++;
    endtask

    task automatic test_full_pop();
        out0_ready = 1'b1; in_valid = 1'b1; select = 1'b0; din = 8'h44;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL fullpop_ready got %b exp 0", in_ready); else pass_cnt++;
        tick();
        total_cnt++;
        if (count0 !== 1 || out0 !== 8'h22) $display("FAIL fullpop_refused got %0d %h exp 1 22", count0, out0); else pass_cnt++;
        out0_ready = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL fullpop_headroom got %b exp 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (count0 !== 2) $display("FAIL fullpop_accept got %0d exp 2", count0); else pass_cnt++;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        tick();
        out0_ready = 1'b0; out1_ready = 1'b0;
        total_cnt++;
        if (count0 !== 0 || count1 !== 0 || out0 !== 8'h44) $display("FAIL fullpop_drain got %0d/%0d %h exp 0/0 44", count0, count1, out0); else pass_cnt++;
    endtask

    task automatic test_wrap();
        int p;
        p = pops0;
        out0_ready = 1'b1;
        select = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 8'(i);
            tick();
            total_cnt++;
            if (out0 !== 8'(i) || count0 !== 1) $display("FAIL wrap_step%0d got %h cnt %0d exp %h cnt 1", i, out0, count0, 8'(i));
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        out0_ready = 1'b0;
        total_cnt++;
        if (count0 !== 0 || out0 !== 8'h09 || (pops0 - p) !== 10)
            $display("FAIL wrap_end got cnt %0d out %h pops %0d exp 0 09 10", count0, out0, pops0 - p);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        din = 8'h01; select = 1'b0; tick();
        din = 8'h02; tick();
        din = 8'h03; select = 1'b1; tick();
        total_cnt++;
        if (count0 !== 2 || count1 !== 1) $display("FAIL rmid_pre got %0d/%0d exp 2/1", count0, count1); else pass_cnt++;
        reset = 1'b1; din = 8'hFF; out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        total_cnt++;
        if (count0 !== 0 || count1 !== 0 || out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0 !== 8'h00 || out1 !== 8'h00)
            $display("FAIL rmid_clear got %0d/%0d v%b%b %h/%h exp 0/0 v00 00/00", count0, count1, out0_valid, out1_valid, out0, out1);
        else pass_cnt++;
        in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        reset = 1'b0;
        tick();
    endtask

`ifdef DEMUX1_2BYTE_BROADCAST_EN
    task automatic test_broadcast();
        broadcast = 1'b1; in_valid = 1'b1; select = 1'b0; din = 8'h7E;
        tick();
        total_cnt++;
        if (count0 !== 1 || count1 !== 1 || out0 !== 8'h7E || out1 !== 8'h7E)
            $display("FAIL bc_push got %0d/%0d %h/%h exp 1/1 7e/7e", count0, count1, out0, out1);
        else pass_cnt++;
        broadcast = 1'b0; select = 1'b1; din = 8'h5A;
        tick();
        in_valid = 1'b0; broadcast = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bc_one_full got %b exp 0", in_ready); else pass_cnt++;
        broadcast = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        tick();
        tick();
        out0_ready = 1'b0; out1_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_steering();
        test_fill();
        test_full_pop();
        test_wrap();
        test_reset_mid();
`ifdef DEMUX1_2BYTE_BROADCAST_EN
        test_broadcast();
`endif
        tick();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_demux1_2byte
`default_nettype wire
